hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, FSM state enum and the minimum wait-counter width.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;

  localparam int WAIT_CNT_MIN_W = 8;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward selection for one execute-stage operand. M-stage result wins over
// W-stage result; register $0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] write_reg_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] write_reg_w_i,
  output logic [1:0] fwd_o
);

  // Priority pick of the youngest in-flight producer
  always_comb begin
    fwd_o = FWD_REG;
    if (reg_write_m_i && (write_reg_m_i != 5'd0) && (write_reg_m_i == src_i))
      fwd_o = FWD_ALUOUTM;
    else if (reg_write_w_i && (write_reg_w_i != 5'd0) && (write_reg_w_i == src_i))
      fwd_o = FWD_RESULTW;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, redirect
// flush and data-memory wait stall with a sticky timeout flag.
// Optional build macro HAZARD_PERF_EN adds stall/flush cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        PCSrcM,
  input  logic        JumpM,
  input  logic        MemReqM,
  input  logic        DmemReady,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
`ifdef HAZARD_PERF_EN
  output logic [31:0] PerfStallCnt,
  output logic [31:0] PerfFlushCnt,
`endif
  output logic        MemTimeout
);

  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > WAIT_CNT_MIN_W) ?
                      $clog2(MEM_TIMEOUT + 1) : WAIT_CNT_MIN_W;

  logic [1:0]    rst_sync_q;
  logic          rst_n_int;
  logic          mem_wait, redirect, load_use, hit;
  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  // Assert immediately, release only after two clean clock edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  fwd_sel u_fwd_a (
    .src_i(RsE), .reg_write_m_i(RegWriteM), .write_reg_m_i(WriteRegM),
    .reg_write_w_i(RegWriteW), .write_reg_w_i(WriteRegW), .fwd_o(ForwardAE)
  );

  fwd_sel u_fwd_b (
    .src_i(RtE), .reg_write_m_i(RegWriteM), .write_reg_m_i(WriteRegM),
    .reg_write_w_i(RegWriteW), .write_reg_w_i(WriteRegW), .fwd_o(ForwardBE)
  );

  assign mem_wait = MemReqM & ~DmemReady;
  assign redirect = PCSrcM | JumpM;
  assign load_use = MemtoRegE & RegWriteE & (WriteRegE != 5'd0) &
                    ((WriteRegE == RsD) | (WriteRegE == RtD));

  // Stall/flush priority: memory wait > redirect > load-use
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0;
    if (mem_wait) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
    end else if (redirect) begin
      FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    end
  end

  // Wait FSM next state; cnt_q holds the MEMWAIT cycle number (1-based)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (mem_wait) begin
          state_d = MEMWAIT;
          cnt_d   = CW'(1);
        end
      end
      MEMWAIT: begin
        if (!mem_wait) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign hit        = (state_q == MEMWAIT) && (cnt_q >= CW'(MEM_TIMEOUT));
  assign MemTimeout = tmo_q | hit;

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_q | hit;
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      PerfStallCnt <= '0;
      PerfFlushCnt <= '0;
    end else begin
      if (StallF) PerfStallCnt <= PerfStallCnt + 32'd1;
      if (FlushE) PerfFlushCnt <= PerfFlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4). A behavioural model
// checks every cycle; directed literal checks pin the model itself.
module tb_hazard_ctrl;

  localparam int MT = 4;

  logic       clk = 1'b0, reset = 1'b0;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcM, JumpM, MemReqM, DmemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStallCnt, PerfFlushCnt;
`endif

  int total = 0, bad = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcM(PCSrcM), .JumpM(JumpM),
    .MemReqM(MemReqM), .DmemReady(DmemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
`ifdef HAZARD_PERF_EN
    .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt),
`endif
    .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int streak = 0;      // consecutive cycles with a pending memory wait
  bit tmo_seen = 0;
`ifdef HAZARD_PERF_EN
  int n_stall = 0, n_flush = 0, rel_edges = 0;
`endif

  function automatic logic [1:0] fwd_m(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  // {SF,SD,SE,SM,FD,FE,FM}
  function automatic logic [6:0] ctl_m();
    bit w, r, lu;
    w  = MemReqM && !DmemReady;
    r  = PCSrcM || JumpM;
    lu = MemtoRegE && RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    if (w)  return 7'b1111_000;
    if (r)  return 7'b0000_111;
    if (lu) return 7'b1100_010;
    return 7'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak = 0; tmo_seen = 0;
`ifdef HAZARD_PERF_EN
      n_stall = 0; n_flush = 0; rel_edges = 0;
`endif
    end else begin
`ifdef HAZARD_PERF_EN
      if (rel_edges >= 2) begin
        if (ctl_m() & 7'b1000_000) n_stall++;
        if (ctl_m() & 7'b0000_010) n_flush++;
      end
      rel_edges++;
`endif
      if (streak >= MT) tmo_seen = 1;
      if (MemReqM && !DmemReady) streak++;
      else streak = 0;
    end
  end

  always @(negedge clk) begin
    chk("model_fwdA", {30'd0, ForwardAE}, {30'd0, fwd_m(RsE)});
    chk("model_fwdB", {30'd0, ForwardBE}, {30'd0, fwd_m(RtE)});
    chk("model_ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM},
        {25'd0, ctl_m()});
    chk("model_tmo", {31'd0, MemTimeout}, {31'd0, (tmo_seen || streak >= MT)});
`ifdef HAZARD_PERF_EN
    chk("model_pstall", PerfStallCnt, n_stall);
    chk("model_pflush", PerfFlushCnt, n_flush);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcM = 0; JumpM = 0; MemReqM = 0; DmemReady = 1;
  endtask

  task automatic nxt();   // drive point just after the active edge
    @(posedge clk); #1;
  endtask

  task automatic settle();  // check point away from the active edge
    @(negedge clk); #1;
  endtask

  initial begin
    idle();
    #3;
    chk("rst_tmo", {31'd0, MemTimeout}, 32'd0);
    chk("rst_stallF", {31'd0, StallF}, 32'd0);
    RegWriteM = 1; WriteRegM = 5; RsE = 5;
    #1;
    chk("rst_comb_fwdA", {30'd0, ForwardAE}, 32'd2);
    idle();
    settle();
    nxt(); reset = 1'b1;
    repeat (3) nxt();

    // M has priority over W
    RegWriteM = 1; WriteRegM = 5; RsE = 5; RegWriteW = 1; WriteRegW = 5;
    settle(); chk("fwdA_M_over_W", {30'd0, ForwardAE}, 32'd2);
    nxt(); RegWriteM = 0; RtE = 5;
    settle(); chk("fwdB_W", {30'd0, ForwardBE}, 32'd1);
    nxt(); idle(); RegWriteM = 1; WriteRegM = 0; RtE = 0;
    settle(); chk("fwdB_r0", {30'd0, ForwardBE}, 32'd0);

    // load-use, one cycle
    nxt(); idle(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    settle();
    chk("lu_stallF", {31'd0, StallF}, 32'd1);
    chk("lu_stallD", {31'd0, StallD}, 32'd1);
    chk("lu_flushE", {31'd0, FlushE}, 32'd1);
    chk("lu_stallE", {31'd0, StallE}, 32'd0);
    nxt(); idle();
    settle(); chk("lu_gone", {31'd0, StallF}, 32'd0);

    // load-use loses to redirect
    nxt(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8; PCSrcM = 1;
    settle();
    chk("redir_flushes", {29'd0, FlushD, FlushE, FlushM}, 32'd7);
    chk("redir_stallF", {31'd0, StallF}, 32'd0);

    // memory wait with a pending jump, then ready
    nxt(); idle(); MemReqM = 1; DmemReady = 0; JumpM = 1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) nxt();
      settle();
      chk("wait_stalls", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
      chk("wait_noflush", {29'd0, FlushD, FlushE, FlushM}, 32'd0);
    end
    nxt(); DmemReady = 1;
    settle();
    chk("ready_flushes", {29'd0, FlushD, FlushE, FlushM}, 32'd7);
    chk("ready_nostall", {31'd0, StallM}, 32'd0);
    nxt(); idle();
    settle(); chk("short_wait_no_tmo", {31'd0, MemTimeout}, 32'd0);

    // mixed forwarding / load-use patterns, checked by the model
    for (int i = 0; i < 16; i++) begin
      nxt();
      RsE = 5'(i % 4); RtE = 5'((i / 2) % 4); WriteRegM = 5'((i / 4) % 4);
      WriteRegW = 5'(i % 3); RegWriteM = i[0]; RegWriteW = i[1];
      RsD = 5'(i % 4); RtD = 5'(3 - i % 4); WriteRegE = 5'((i + 1) % 4);
      MemtoRegE = i[2]; RegWriteE = i[3]; PCSrcM = (i == 7);
    end
    nxt(); idle();

    // timeout: rises on the 4th MEMWAIT cycle (5th wait cycle) and sticks
    nxt(); MemReqM = 1; DmemReady = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) nxt();
      settle();
      chk("tmo_seq", {31'd0, MemTimeout}, (k >= 5) ? 32'd1 : 32'd0);
      chk("tmo_stall", {31'd0, StallF}, 32'd1);
    end
    nxt(); idle();
    settle(); chk("tmo_sticky", {31'd0, MemTimeout}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("tmo_async_clear", {31'd0, MemTimeout}, 32'd0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
